// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for bit_serial_adder.
// master: drives start/a/b/cin, observes busy/done/sum/cout/ov.
// slave : the adder side of the same signals.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ov;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ov
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ov
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: captures a, b, cin on an accepted start, adds
// one bit per clock LSB first through a single full-adder cell with a
// registered carry, then presents sum, cout and signed overflow with a
// one-cycle done strobe.
// Ports:
//   clk   - system clock, rising edge
//   Reset - asynchronous active-low reset
//   bus   - slave side of bit_serial_adder_if (start/a/b/cin in,
//           busy/done/sum/cout/ov out)
module bit_serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 Reset,
  bit_serial_adder_if.slave    bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] s_sh_q,  s_sh_d;
  logic             c_q,     c_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ov_q,    ov_d;

  // Single full-adder cell on the current LSBs and the registered carry.
  logic s_bit_c;
  logic c_new_c;
  assign s_bit_c = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_new_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ov_d    = ov_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        s_sh_d = {s_bit_c, s_sh_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        c_d    = c_new_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // c_q here is the carry into the MSB; c_new_c is the carry out.
          sum_d   = {s_bit_c, s_sh_q[WIDTH-1:1]};
          cout_d  = c_new_c;
          ov_d    = c_q ^ c_new_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
    end
  end

  // Status is decoded straight from the state register.
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ov   = ov_q;

endmodule
